alu_sequencer: RTL and testbench

Multi-cycle execute sequencer that sits directly upstream of the registered 32-bit ALU. It accepts one R-type instruction at a time and reads both source operands from an internal 32×32 register file. It drives the ALU's `a`, `b` and `alu_control` inputs, waits out the ALU's two registered stages (result, then zero flag), and writes the result back to the register file with a writeback pulse.

---
 rtl/alu_pkg.sv | 46 ++++
 rtl/alu_sequencer_reg_file.sv | 42 ++++
 rtl/alu_sequencer.sv | 166 ++++++++++++++++
 tb/tb_alu_sequencer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU execute sequencer.
//   - R-type funct codes accepted by the sequencer
//   - alu_control encodings driven to the registered ALU
//   - sequencer state enum and a funct decode helper
package alu_pkg;

  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_MUL = 6'h18;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_MUL = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_RESULT = 2'd2,
    S_FLAG   = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic       legal;
    logic [2:0] code;
  } decode_t;

  function automatic decode_t decode_funct(input logic [5:0] funct);
    decode_t d;
    d.legal = 1'b1;
    d.code  = ALU_AND;
    case (funct)
      FUNCT_AND: d.code = ALU_AND;
      FUNCT_OR:  d.code = ALU_OR;
      FUNCT_ADD: d.code = ALU_ADD;
      FUNCT_SUB: d.code = ALU_SUB;
      FUNCT_MUL: d.code = ALU_MUL;
      default:   d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_sequencer_reg_file.sv
// reg_file: 2**ADDR_W x DATA_W register file for the execute sequencer.
// Ports:
//   clk, rst_n            clock, async active-low clear of every entry
//   we, waddr, wdata      synchronous write port (writes to entry 0 dropped)
//   ra_addr / ra_data     combinational read port A (rs)
//   rb_addr / rb_data     combinational read port B (rt)
//   rdbg_addr / rdbg_data combinational debug read port
module reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] ra_addr,
  output logic [DATA_W-1:0] ra_data,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] rb_data,
  input  logic [ADDR_W-1:0] rdbg_addr,
  output logic [DATA_W-1:0] rdbg_data
);

  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else if (we && (waddr != '0)) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Entry 0 is never written, but gate the reads too so x0 is zero by construction.
  assign ra_data   = (ra_addr   == '0) ? '0 : mem_q[ra_addr];
  assign rb_data   = (rb_addr   == '0) ? '0 : mem_q[rb_addr];
  assign rdbg_data = (rdbg_addr == '0) ? '0 : mem_q[rdbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle execute sequencer in front of a two-stage
// registered ALU. Accepts one R-type instruction at a time, reads rs/rt from
// the internal register file, drives the ALU, waits for result then zero flag,
// and writes the result back with a one-cycle writeback pulse.
// Ports:
//   instr_valid/instr_ready          instruction handshake (ready only in IDLE)
//   instr_funct/rs/rt/rd             instruction fields
//   alu_a/alu_b/alu_control          registered ALU inputs
//   alu_result/alu_zero              registered ALU outputs
//   wb_valid/wb_rd/wb_data/wb_zero   writeback pulse and its payload
//   illegal                          one-cycle pulse for unsupported funct
//   dbg_addr/dbg_data                combinational register file peek
//
// state    | meaning
// S_IDLE   | ready for an instruction; operands loaded on accept
// S_ISSUE  | ALU operands stable, ALU captures result at end of cycle
// S_RESULT | alu_result valid and captured, ALU captures zero at end of cycle
// S_FLAG   | alu_zero valid; write back and return to IDLE
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [5:0]            instr_funct,
  input  logic [REG_ADDR_W-1:0] instr_rs,
  input  logic [REG_ADDR_W-1:0] instr_rt,
  input  logic [REG_ADDR_W-1:0] instr_rd,
  output logic [DATA_W-1:0]     alu_a,
  output logic [DATA_W-1:0]     alu_b,
  output logic [2:0]            alu_control,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic                  alu_zero,
  output logic                  wb_valid,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [DATA_W-1:0]     wb_data,
  output logic                  wb_zero,
  output logic                  illegal,
  input  logic [REG_ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0]     dbg_data
);

  seq_state_t            state_q, state_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0]     res_q, res_d;
  logic [DATA_W-1:0]     alu_a_q, alu_a_d;
  logic [DATA_W-1:0]     alu_b_q, alu_b_d;
  logic [2:0]            alu_ctl_q, alu_ctl_d;
  logic                  wb_valid_q, wb_valid_d;
  logic [REG_ADDR_W-1:0] wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0]     wb_data_q, wb_data_d;
  logic                  wb_zero_q, wb_zero_d;
  logic                  illegal_q, illegal_d;

  logic                  rf_we;
  logic [DATA_W-1:0]     rs_data, rt_data;
  decode_t               dec;

  reg_file #(
    .DATA_W (DATA_W),
    .ADDR_W (REG_ADDR_W)
  ) u_rf (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (rf_we),
    .waddr     (rd_q),
    .wdata     (res_q),
    .ra_addr   (instr_rs),
    .ra_data   (rs_data),
    .rb_addr   (instr_rt),
    .rb_data   (rt_data),
    .rdbg_addr (dbg_addr),
    .rdbg_data (dbg_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rd_q       <= '0;
      res_q      <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_ctl_q  <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      wb_zero_q  <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_q       <= rd_d;
      res_q      <= res_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_ctl_q  <= alu_ctl_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      wb_zero_q  <= wb_zero_d;
      illegal_q  <= illegal_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rd_d       = rd_q;
    res_d      = res_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_ctl_d  = alu_ctl_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    wb_zero_d  = wb_zero_q;
    illegal_d  = 1'b0;
    rf_we      = 1'b0;
    dec        = decode_funct(instr_funct);

    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          rd_d = instr_rd;
          if (dec.legal) begin
            alu_a_d   = rs_data;
            alu_b_d   = rt_data;
            alu_ctl_d = dec.code;
            state_d   = S_ISSUE;
          end else begin
            // ALU inputs deliberately left alone so it keeps its last operands.
            illegal_d = 1'b1;
          end
        end
      end
      S_ISSUE:  state_d = S_RESULT;
      S_RESULT: begin
        res_d   = alu_result;
        state_d = S_FLAG;
      end
      S_FLAG: begin
        // Write lands on the IDLE-return edge, so a dependent successor sees it.
        rf_we      = 1'b1;
        wb_valid_d = 1'b1;
        wb_rd_d    = rd_q;
        wb_data_d  = res_q;
        wb_zero_d  = alu_zero;
        state_d    = S_IDLE;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  assign instr_ready = (state_q == S_IDLE);
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_control = alu_ctl_q;
  assign wb_valid    = wb_valid_q;
  assign wb_rd       = wb_rd_q;
  assign wb_data     = wb_data_q;
  assign wb_zero     = wb_zero_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer. The registered ALU is modelled here; its result
// register can be overridden (inj_en/inj_val) so nonzero values can be
// seeded into a register file that resets to all zeros.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [5:0]  instr_funct;
  logic [4:0]  instr_rs, instr_rt, instr_rd;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  alu_control;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_zero;
  logic        illegal;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  alu_sequencer #(.DATA_W(32), .REG_ADDR_W(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_funct (instr_funct),
    .instr_rs    (instr_rs),
    .instr_rt    (instr_rt),
    .instr_rd    (instr_rd),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_control (alu_control),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .wb_zero     (wb_zero),
    .illegal     (illegal),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Two-stage registered ALU: result, then zero flag from the registered result.
  logic        inj_en = 1'b0;
  logic [31:0] inj_val = '0;

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] c);
    logic [31:0] r;
    case (c)
      3'b000:  r = a & b;
      3'b001:  r = a | b;
      3'b010:  r = a + b;
      3'b110:  r = a - b;
      3'b111:  r = a * b;
      default: r = '0;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_result <= '0;
      alu_zero   <= 1'b0;
    end else begin
      alu_result <= inj_en ? inj_val : alu_f(alu_a, alu_b, alu_control);
      alu_zero   <= (alu_result == '0);
    end
  end

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        zero;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // Monitor: every writeback pulse pops one expectation.
  always @(negedge clk) begin
    if (rst_n && wb_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_wb: got rd=%0d data=%h expected no writeback", wb_rd, wb_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wb_rd",   32'(wb_rd),   32'(e.rd));
        chk("wb_data", wb_data,      e.data);
        chk("wb_zero", 32'(wb_zero), 32'(e.zero));
        chk("wb_latency", 32'(cyc - e.acc), 32'd3);
      end
    end
  end

  // Present an instruction at a negedge and hold it until accepted.
  task automatic issue(input logic [5:0] f, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input bit push, input logic [31:0] d,
                       input bit z, output int acc);
    bit done;
    done = 0;
    acc  = -1;
    @(negedge clk);
    instr_valid = 1'b1;
    instr_funct = f;
    instr_rs    = rs;
    instr_rt    = rt;
    instr_rd    = rd;
    for (int k = 0; k < 20 && !done; k++) begin
      bit rdy;
      rdy = instr_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        done = 1;
        acc  = cyc;
        if (push) begin
          exp_t e;
          e.rd = rd; e.data = d; e.zero = z; e.acc = acc;
          exp_q.push_back(e);
        end
      end
    end
    instr_valid = 1'b0;
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: got no accept expected accept within 20 cycles");
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && instr_ready) ok = 1;
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL idle_timeout: got pending=%0d expected 0", exp_q.size());
    end
  endtask

  task automatic chk_reg(input string nm, input logic [4:0] idx, input logic [31:0] expv);
    dbg_addr = idx;
    #1;
    chk(nm, dbg_data, expv);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1;
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr_funct = '0;
    instr_rs    = '0;
    instr_rt    = '0;
    instr_rd    = '0;
    dbg_addr    = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready",   32'(instr_ready), 32'd1);
    chk("rst_alu_a",   alu_a,            32'd0);
    chk("rst_alu_ctl", 32'(alu_control), 32'd0);
    chk("rst_wb",      32'(wb_valid),    32'd0);
    chk("rst_illegal", 32'(illegal),     32'd0);

    // ADD r0+r0 -> r3
    issue(6'h20, 5'd0, 5'd0, 5'd3, 1, 32'd0, 1'b1, a0);
    wait_idle();
    chk_reg("r3_zero", 5'd3, 32'd0);

    // Seed r1=5, r2=7, r7=0x10000 through the ALU override
    inj_en = 1'b1; inj_val = 32'd5;
    issue(6'h20, 5'd0, 5'd0, 5'd1, 1, 32'd5, 1'b0, a0);
    wait_idle();
    inj_val = 32'd7;
    issue(6'h20, 5'd0, 5'd0, 5'd2, 1, 32'd7, 1'b0, a0);
    wait_idle();
    inj_val = 32'h0001_0000;
    issue(6'h20, 5'd0, 5'd0, 5'd7, 1, 32'h0001_0000, 1'b0, a0);
    wait_idle();
    inj_en = 1'b0;
    chk_reg("r1_seed", 5'd1, 32'd5);
    chk_reg("r2_seed", 5'd2, 32'd7);

    // ADD r4 = r1 + r2
    issue(6'h20, 5'd1, 5'd2, 5'd4, 1, 32'd12, 1'b0, a0);
    chk("add_alu_a",   alu_a,            32'd5);
    chk("add_alu_b",   alu_b,            32'd7);
    chk("add_alu_ctl", 32'(alu_control), 32'(3'b010));
    wait_idle();

    // SUB r8 = r1 - r2 (wraps); MUL r9 = r7 * r7 (low word zero)
    issue(6'h22, 5'd1, 5'd2, 5'd8, 1, 32'hFFFF_FFFE, 1'b0, a0);
    chk("sub_alu_ctl", 32'(alu_control), 32'(3'b110));
    wait_idle();
    issue(6'h18, 5'd7, 5'd7, 5'd9, 1, 32'd0, 1'b1, a0);
    wait_idle();
    chk_reg("r8_sub", 5'd8, 32'hFFFF_FFFE);

    // Illegal funct 0x2A
    issue(6'h2A, 5'd1, 5'd2, 5'd10, 0, 32'd0, 1'b0, a0);
    chk("ill_pulse",   32'(illegal),     32'd1);
    chk("ill_ready",   32'(instr_ready), 32'd1);
    chk("ill_alu_ctl", 32'(alu_control), 32'(3'b111));
    chk("ill_alu_a",   alu_a,            32'h0001_0000);
    @(posedge clk);
    #1;
    chk("ill_one_cycle", 32'(illegal),   32'd0);
    chk_reg("r10_untouched", 5'd10, 32'd0);

    // OR into r0: writeback shows the true value, r0 stays 0
    issue(6'h25, 5'd1, 5'd2, 5'd0, 1, 32'd7, 1'b0, a0);
    wait_idle();
    chk_reg("r0_zero", 5'd0, 32'd0);

    // Back-to-back dependency: r5 = r1+r2, then r6 = r5+r5 presented while busy
    issue(6'h20, 5'd1, 5'd2, 5'd5, 1, 32'd12, 1'b0, a0);
    issue(6'h20, 5'd5, 5'd5, 5'd6, 1, 32'd24, 1'b0, a1);
    chk("b2b_spacing", 32'(a1 - a0), 32'd4);
    wait_idle();
    chk_reg("r6_dep", 5'd6, 32'd24);

    // Reset while in RESULT: nothing written back
    issue(6'h20, 5'd1, 5'd1, 5'd11, 0, 32'd0, 1'b0, a0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_alu_a",   alu_a,            32'd0);
    chk("arst_alu_ctl", 32'(alu_control), 32'd0);
    chk("arst_ready",   32'(instr_ready), 32'd1);
    chk("arst_wb",      32'(wb_valid),    32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk_reg("r11_not_written", 5'd11, 32'd0);
    chk("post_rst_ready", 32'(instr_ready), 32'd1);

    issue(6'h20, 5'd0, 5'd0, 5'd12, 1, 32'd0, 1'b1, a0);
    wait_idle();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
